// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan decoder: segment patterns,
// character codes, FSM states and anode helpers.
package seg_pkg;

  typedef logic [4:0] code_t;
  typedef logic [6:0] seg_t;

  typedef enum logic {StOff, StCapture} state_e;

  localparam code_t CODE_L     = 5'h10;
  localparam code_t CODE_UNK   = 5'h1E;
  localparam code_t CODE_BLANK = 5'h1F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Patterns are {g,f,e,d,c,b,a}, active-low.
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_L     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic logic an_valid(input logic [3:0] an);
    return an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] an_pos(input logic [3:0] an);
    case (an)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic frame_has_unk(input logic [19:0] frame);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (frame[5*p +: 5] == CODE_UNK) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational map from an active-low segment pattern to a 5-bit character code.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  seg_t  pattern,
  output code_t code
);

  always_comb begin
    code = CODE_UNK;
    case (pattern)
      SEG_0:     code = 5'h00;
      SEG_1:     code = 5'h01;
      SEG_2:     code = 5'h02;
      SEG_3:     code = 5'h03;
      SEG_4:     code = 5'h04;
      SEG_5:     code = 5'h05;
      SEG_6:     code = 5'h06;
      SEG_7:     code = 5'h07;
      SEG_8:     code = 5'h08;
      SEG_9:     code = 5'h09;
      SEG_A:     code = 5'h0A;
      SEG_B:     code = 5'h0B;
      SEG_C:     code = 5'h0C;
      SEG_D:     code = 5'h0D;
      SEG_E:     code = 5'h0E;
      SEG_F:     code = 5'h0F;
      SEG_L:     code = CODE_L;
      SEG_BLANK: code = CODE_BLANK;
      default:   code = CODE_UNK;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed four-digit seven-segment bus and rebuilds the displayed
// characters into frames, flagging blanking and multi-anode bus errors.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned BLANK_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  disp,
  input  logic [3:0]  an,
  output logic [19:0] chars,
  output logic        frame_valid,
  output logic        display_off,
  output logic        bad_an,
  output logic        unknown
);

  localparam logic [7:0] STABLE_TH = 8'(STABLE_CYCLES);
  localparam logic [7:0] BLANK_TH  = 8'(BLANK_CYCLES);

  logic [3:0]       an_q;
  seg_t             disp_q;
  logic [7:0]       stab_q, stab_d;
  logic             done_q, done_d;
  logic [7:0]       blank_q, blank_d;
  logic [3:0]       seen_q, seen_d;
  code_t [3:0]      pending_q, pending_d;
  logic [19:0]      chars_q, chars_d;
  logic             frame_q, frame_d;
  logic             bad_q, bad_d;
  logic             unk_q, unk_d;
  state_e           state_q, state_d;

  code_t            code;
  logic             reload;
  logic             commit;
  logic             blank_sample;
  logic             blank_hit;
  logic [7:0]       blank_inc;
  logic [1:0]       pos;

  seg_pattern_decode u_decode (
    .pattern (disp_q),
    .code    (code)
  );

  always_comb begin
    // A multi-anode sample restarts the run so it can never extend a valid one.
    reload = ({an, disp} != {an_q, disp_q}) ||
             (!an_valid(an) && (an != AN_OFF));
    stab_d = reload ? 8'd1 : ((stab_q == 8'hFF) ? stab_q : stab_q + 8'd1);

    commit = an_valid(an_q) && (stab_q == STABLE_TH) && !done_q;
    done_d = reload ? 1'b0 : (done_q | commit);
    pos    = an_pos(an_q);

    blank_sample = (an_q == AN_OFF);
    blank_inc    = (blank_q == 8'hFF) ? blank_q : blank_q + 8'd1;
    blank_d      = blank_sample ? blank_inc : 8'd0;
    blank_hit    = blank_sample && (blank_inc >= BLANK_TH);

    bad_d     = !an_valid(an_q) && !blank_sample;
    pending_d = pending_q;
    seen_d    = seen_q;
    chars_d   = chars_q;
    frame_d   = 1'b0;
    unk_d     = unk_q;
    state_d   = state_q;

    if (commit) begin
      pending_d[pos] = code;
      seen_d         = seen_q | (4'b0001 << pos);
      state_d        = StCapture;
      if (seen_d == 4'b1111) begin
        chars_d = pending_d;
        frame_d = 1'b1;
        unk_d   = frame_has_unk(pending_d);
        seen_d  = 4'b0000;
      end
    end else if (blank_hit) begin
      seen_d  = 4'b0000;
      state_d = StOff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q      <= AN_OFF;
      disp_q    <= SEG_BLANK;
      stab_q    <= 8'd0;
      done_q    <= 1'b0;
      blank_q   <= 8'd0;
      seen_q    <= 4'b0000;
      pending_q <= {4{CODE_BLANK}};
      chars_q   <= {4{CODE_BLANK}};
      frame_q   <= 1'b0;
      bad_q     <= 1'b0;
      unk_q     <= 1'b0;
      state_q   <= StOff;
    end else begin
      an_q      <= an;
      disp_q    <= disp;
      stab_q    <= stab_d;
      done_q    <= done_d;
      blank_q   <= blank_d;
      seen_q    <= seen_d;
      pending_q <= pending_d;
      chars_q   <= chars_d;
      frame_q   <= frame_d;
      bad_q     <= bad_d;
      unk_q     <= unk_d;
      state_q   <= state_d;
    end
  end

  assign chars       = chars_q;
  assign frame_valid = frame_q;
  assign bad_an      = bad_q;
  assign unknown     = unk_q;
  assign display_off = (state_q == StOff);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: two instances (STABLE_CYCLES 1 and 3) share the pins;
// expected frames are queued per instance when stimulus is driven.
module tb_seg_scan_decoder;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000, P4 = 7'b0011001, PS = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000, PA = 7'b0001000, PB = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110;
  localparam logic [6:0] PF = 7'b0001110, PL = 7'b1000111, PX = 7'b1010101;
  localparam logic [6:0] PBLK = 7'b1111111;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  disp;
    int          hold;
    bit          f1;
    bit          f3;
    logic [19:0] exp;
    bit          unk;
  } vec_t;

  typedef struct {
    logic [19:0] chars;
    logic        unk;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  disp_pin = 7'b1111111;
  logic [3:0]  an_pin = 4'b1111;
  logic [19:0] chars1, chars3;
  logic        fv1, fv3, off1, off3, bad1, bad3, unk1, unk3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q3[$];
  vec_t tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_decoder #(.STABLE_CYCLES(1), .BLANK_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .disp(disp_pin), .an(an_pin), .chars(chars1),
    .frame_valid(fv1), .display_off(off1), .bad_an(bad1), .unknown(unk1)
  );

  seg_scan_decoder #(.STABLE_CYCLES(3), .BLANK_CYCLES(4)) dut3 (
    .clk(clk), .rst(rst), .disp(disp_pin), .an(an_pin), .chars(chars3),
    .frame_valid(fv3), .display_off(off3), .bad_an(bad3), .unknown(unk3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] an, input logic [6:0] disp, input int hold,
                              input bit f1, input bit f3, input logic [19:0] exp,
                              input bit unk);
    vec_t v;
    v.an = an; v.disp = disp; v.hold = hold;
    v.f1 = f1; v.f3 = f3; v.exp = exp; v.unk = unk;
    return v;
  endfunction

  // A run captured at edge C commits at C+STABLE_CYCLES.
  task automatic run_row(input vec_t v);
    exp_t e;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      if (i == 0) begin
        e.chars = v.exp;
        e.unk   = v.unk;
        if (v.f1) begin e.cyc = cyc + 2; q1.push_back(e); end
        if (v.f3) begin e.cyc = cyc + 4; q3.push_back(e); end
      end
      an_pin   = v.an;
      disp_pin = v.disp;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && fv1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut1_frame: unexpected frame_valid chars=%h cyc=%0d", chars1, cyc);
      end else begin
        e = q1.pop_front();
        check("dut1_frame_chars", 32'(chars1), 32'(e.chars));
        check("dut1_frame_unknown", 32'(unk1), 32'(e.unk));
        check("dut1_frame_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && fv3) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut3_frame: unexpected frame_valid chars=%h cyc=%0d", chars3, cyc);
      end else begin
        e = q3.pop_front();
        check("dut3_frame_chars", 32'(chars3), 32'(e.chars));
        check("dut3_frame_unknown", 32'(unk3), 32'(e.unk));
        check("dut3_frame_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [19:0] f_ecls, f_1234, f_unk, f_known, f_blank;
    f_ecls  = {5'h0E, 5'h05, 5'h10, 5'h0C};
    f_1234  = {5'h04, 5'h03, 5'h02, 5'h01};
    f_unk   = {5'h0F, 5'h0B, 5'h0A, 5'h1E};
    f_known = {5'h07, 5'h00, 5'h0D, 5'h08};
    f_blank = {5'h0E, 5'h0C, 5'h02, 5'h01};

    // Rotation with 1-cycle digits: only the STABLE_CYCLES=1 instance sees frames.
    for (int r = 0; r < 3; r++) begin
      tbl.push_back(mk(4'b0111, PE, 1, 0, 0, 0, 0));
      tbl.push_back(mk(4'b1110, PC, 1, 0, 0, 0, 0));
      tbl.push_back(mk(4'b1101, PL, 1, 0, 0, 0, 0));
      tbl.push_back(mk(4'b1011, PS, 1, 1, 0, f_ecls, 0));
    end
    // 2-cycle digits: still too short for STABLE_CYCLES=3.
    tbl.push_back(mk(4'b0111, PE, 2, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1110, PC, 2, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1101, PL, 2, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1011, PS, 2, 1, 0, f_ecls, 0));
    // 3-cycle digits: both instances frame.
    tbl.push_back(mk(4'b0111, PE, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1110, PC, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1101, PL, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1011, PS, 3, 1, 1, f_ecls, 0));
    tbl.push_back(mk(4'b1110, P1, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1101, P2, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1011, P3, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0111, P4, 3, 1, 1, f_1234, 0));
    tbl.push_back(mk(4'b1110, PX, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1101, PA, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1011, PB, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0111, PF, 3, 1, 1, f_unk, 1));
    tbl.push_back(mk(4'b1110, P8, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1101, PD, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b1011, P0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0111, P7, 3, 1, 1, f_known, 0));

    repeat (3) @(negedge clk);
    check("dut1_rst_chars", 32'(chars1), 32'hFFFFF);
    check("dut1_rst_frame_valid", 32'(fv1), 0);
    check("dut1_rst_bad_an", 32'(bad1), 0);
    check("dut1_rst_unknown", 32'(unk1), 0);
    check("dut1_rst_display_off", 32'(off1), 1);
    check("dut3_rst_chars", 32'(chars3), 32'hFFFFF);
    check("dut3_rst_display_off", 32'(off3), 1);
    rst = 1'b0;

    foreach (tbl[i]) run_row(tbl[i]);
    repeat (4) @(negedge clk);
    check("dut1_display_on", 32'(off1), 0);
    check("dut3_display_on", 32'(off3), 0);

    // Blanking mid-frame must discard the two digits already seen.
    run_row(mk(4'b1110, P9, 3, 0, 0, 0, 0));
    run_row(mk(4'b1101, P6, 3, 0, 0, 0, 0));
    run_row(mk(4'b1111, PBLK, 4, 0, 0, 0, 0));
    @(negedge clk);
    check("dut1_off_before_threshold", 32'(off1), 0);
    check("dut3_off_before_threshold", 32'(off3), 0);
    an_pin = 4'b1011; disp_pin = PC;
    @(negedge clk);
    check("dut1_off_at_threshold", 32'(off1), 1);
    check("dut3_off_at_threshold", 32'(off3), 1);
    run_row(mk(4'b1011, PC, 1, 0, 0, 0, 0));
    run_row(mk(4'b0111, PE, 3, 0, 0, 0, 0));
    run_row(mk(4'b1110, P1, 3, 0, 0, 0, 0));
    run_row(mk(4'b1101, P2, 3, 1, 1, f_blank, 0));
    repeat (4) @(negedge clk);
    check("dut1_off_after_commit", 32'(off1), 0);
    check("dut3_off_after_commit", 32'(off3), 0);

    // Two anodes low for a single sample.
    @(negedge clk);
    an_pin = 4'b0011; disp_pin = P8;
    @(negedge clk);
    check("dut1_bad_an_early", 32'(bad1), 0);
    an_pin = 4'b1111; disp_pin = PBLK;
    @(negedge clk);
    check("dut1_bad_an_pulse", 32'(bad1), 1);
    check("dut3_bad_an_pulse", 32'(bad3), 1);
    @(negedge clk);
    check("dut1_bad_an_clear", 32'(bad1), 0);
    check("dut3_bad_an_clear", 32'(bad3), 0);
    check("dut1_chars_after_bad", 32'(chars1), 32'(f_blank));
    check("dut3_chars_after_bad", 32'(chars3), 32'(f_blank));

    // Reset after three commits; the fourth digit alone must not complete a frame.
    run_row(mk(4'b1110, P3, 3, 0, 0, 0, 0));
    run_row(mk(4'b1101, P4, 3, 0, 0, 0, 0));
    run_row(mk(4'b1011, PS, 3, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b1; an_pin = 4'b1111; disp_pin = PBLK;
    #1;
    check("dut1_mid_rst_chars", 32'(chars1), 32'hFFFFF);
    check("dut1_mid_rst_frame_valid", 32'(fv1), 0);
    check("dut1_mid_rst_bad_an", 32'(bad1), 0);
    check("dut1_mid_rst_unknown", 32'(unk1), 0);
    check("dut1_mid_rst_display_off", 32'(off1), 1);
    check("dut3_mid_rst_chars", 32'(chars3), 32'hFFFFF);
    check("dut3_mid_rst_display_off", 32'(off3), 1);
    @(negedge clk);
    rst = 1'b0;
    run_row(mk(4'b0111, P6, 3, 0, 0, 0, 0));
    repeat (6) @(negedge clk);
    check("dut1_off_after_rst_commit", 32'(off1), 0);
    check("dut3_off_after_rst_commit", 32'(off3), 0);
    check("dut1_chars_after_rst", 32'(chars1), 32'hFFFFF);
    check("dut1_frames_outstanding", q1.size(), 0);
    check("dut3_frames_outstanding", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
